// File: rtl/pp_pipeline_accel_muladd_pipe.sv
// pp_pipeline_accel_muladd_pipe
// Three-stage multiply-add with valid/ready back-pressure:
//   out = round((A*B) + C)  or  round((A*B) + ACC)
// Optional macro PP_MULADD_SAT_EN: clip the result to OUT_W bits and flag it on
// out_sat. Without it the result wraps to OUT_W bits and out_sat is tied 0.
module pp_pipeline_accel_muladd_pipe #(
  parameter int A_W      = 12,
  parameter int B_W      = 9,
  parameter int C_W      = 21,
  parameter int OUT_W    = 22,
  parameter int A_SIGNED = 0,
  parameter int B_SIGNED = 1,
  parameter int SHIFT    = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [A_W-1:0]          in_a,
  input  logic [B_W-1:0]          in_b,
  input  logic signed [C_W-1:0]   in_c,
  input  logic                    in_acc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_dout,
  output logic                    out_sat
);

  // Product is exact in PW bits; the sum is one bit wider than its widest
  // contributor (at least 48) so it never overflows internally.
  localparam int PW     = A_W + B_W + 2;
  localparam int MX     = (PW > C_W) ? PW : C_W;
  localparam int SW     = ((MX > 48) ? MX : 48) + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [SW-1:0] RND_ADD = (SHIFT > 0) ? (SW'(1) << RND_SH) : '0;

  // Round half up, then arithmetic shift; SHIFT = 0 leaves the sum untouched.
  function automatic logic signed [SW-1:0] round_shift(input logic signed [SW-1:0] s);
    return (s + RND_ADD) >>> SHIFT;
  endfunction

`ifdef PP_MULADD_SAT_EN
  localparam logic signed [SW-1:0] MAX_V = SW'({(OUT_W-1){1'b1}});
  localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

  // Returns {clipped flag, OUT_W-bit result}.
  function automatic logic [OUT_W:0] saturate(input logic signed [SW-1:0] r);
    if (r > MAX_V)      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    else if (r < MIN_V) return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else                return {1'b0, r[OUT_W-1:0]};
  endfunction
`endif

  logic                    w_en;
  logic signed [A_W:0]     w_a_ext;
  logic signed [B_W:0]     w_b_ext;
  logic signed [PW-1:0]    w_m;
  logic signed [SW-1:0]    w_addend;
  logic signed [SW-1:0]    w_sum;
  logic signed [SW-1:0]    w_r;
  logic signed [OUT_W-1:0] w_dout;

  logic                    r_vld_p0;
  logic [A_W-1:0]          r_a_p0;
  logic [B_W-1:0]          r_b_p0;
  logic signed [C_W-1:0]   r_c_p0;
  logic                    r_sel_p0;

  logic                    r_vld_p1;
  logic signed [PW-1:0]    r_m_p1;
  logic signed [C_W-1:0]   r_c_p1;
  logic                    r_sel_p1;

  logic                    r_vld_p2;
  logic signed [OUT_W-1:0] r_dout_p2;
  logic signed [SW-1:0]    r_acc;

  // One global advance: the whole pipe moves unless a held result is blocked.
  assign w_en      = !r_vld_p2 || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld_p2;
  assign out_dout  = r_dout_p2;

  assign w_a_ext  = (A_SIGNED != 0) ? $signed({r_a_p0[A_W-1], r_a_p0}) : $signed({1'b0, r_a_p0});
  assign w_b_ext  = (B_SIGNED != 0) ? $signed({r_b_p0[B_W-1], r_b_p0}) : $signed({1'b0, r_b_p0});
  assign w_m      = PW'(w_a_ext) * PW'(w_b_ext);
  assign w_addend = r_sel_p1 ? r_acc : SW'(r_c_p1);
  assign w_sum    = SW'(r_m_p1) + w_addend;
  assign w_r      = round_shift(w_sum);

`ifdef PP_MULADD_SAT_EN
  logic [OUT_W:0] w_satres;
  logic           r_sat_p2;

  assign w_satres = saturate(w_r);
  assign w_dout   = w_satres[OUT_W-1:0];
  assign out_sat  = r_sat_p2;

  // Clip flag travels with the S3 result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sat_p2 <= 1'b0;
    end else if (w_en && r_vld_p1) begin
      r_sat_p2 <= w_satres[OUT_W];
    end
  end
`else
  logic w_unused_hi;

  assign w_dout      = w_r[OUT_W-1:0];
  assign out_sat     = 1'b0;
  assign w_unused_hi = ^w_r[SW-1:OUT_W];
`endif

  // Stage valids advance together on en; in-flight beats are dropped on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else if (w_en) begin
      r_vld_p0 <= in_valid;
      r_vld_p1 <= r_vld_p0;
    end
  end

  // ---- S1 operand regs / S2 product reg (data follows en, bubbles included)
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_a_p0   <= in_a;
      r_b_p0   <= in_b;
      r_c_p0   <= in_c;
      r_sel_p0 <= in_acc;
      r_m_p1   <= w_m;
      r_c_p1   <= r_c_p0;
      r_sel_p1 <= r_sel_p0;
    end
  end

  // ---- S3 result reg and accumulator (accumulator only moves on valid beats)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p2  <= 1'b0;
      r_dout_p2 <= '0;
      r_acc     <= '0;
    end else if (w_en) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_dout_p2 <= w_dout;
        r_acc     <= w_sum;
      end
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_muladd_pipe.sv
// Scoreboard bench for pp_pipeline_accel_muladd_pipe: a default instance plus
// a SHIFT=4 instance and an OUT_W=8 instance driven from a shared stimulus.
module tb_pp_pipeline_accel_muladd_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic               in_valid, in_ready, in_acc, out_valid, out_ready, out_sat;
  logic [11:0]        in_a;
  logic [8:0]         in_b;
  logic signed [20:0] in_c;
  logic [21:0]        out_dout;

  logic               x_valid, x_acc, sh_ready, sh_valid, sh_sat, ow_ready, ow_valid, ow_sat;
  logic [11:0]        x_a;
  logic [8:0]         x_b;
  logic signed [20:0] x_c;
  logic [21:0]        sh_dout;
  logic [7:0]         ow_dout;

  pp_pipeline_accel_muladd_pipe #(.A_W(12), .B_W(9), .C_W(21), .OUT_W(22),
    .A_SIGNED(0), .B_SIGNED(1), .SHIFT(0)) u_main (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_dout(out_dout), .out_sat(out_sat));

  pp_pipeline_accel_muladd_pipe #(.SHIFT(4)) u_sh (
    .clk(clk), .reset_n(reset_n), .in_valid(x_valid), .in_ready(sh_ready),
    .in_a(x_a), .in_b(x_b), .in_c(x_c), .in_acc(x_acc),
    .out_valid(sh_valid), .out_ready(1'b1), .out_dout(sh_dout), .out_sat(sh_sat));

  pp_pipeline_accel_muladd_pipe #(.OUT_W(8)) u_ow (
    .clk(clk), .reset_n(reset_n), .in_valid(x_valid), .in_ready(ow_ready),
    .in_a(x_a), .in_b(x_b), .in_c(x_c), .in_acc(x_acc),
    .out_valid(ow_valid), .out_ready(1'b1), .out_dout(ow_dout), .out_sat(ow_sat));

  int n_tests = 0;
  int n_fail  = 0;
  int q_m[$];
  int q_sh[$];
  int q_ow[$];
  bit q_ows[$];
  int rdy_low = 0;
  int run = 0;
  int max_run = 0;
  bit done_rand;
  int ra, rb, rc;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Main monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    int e;
    if (out_valid === 1'b1) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q_m.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL main_unexpected: got %0d, expected no output", $signed(out_dout));
      end else begin
        e = q_m.pop_front();
        check("main_dout", $signed(out_dout), e);
        check("main_sat", out_sat, 0);
      end
    end
  end

  // SHIFT=4 monitor.
  always @(negedge clk) begin
    int e;
    if (sh_valid === 1'b1) begin
      if (q_sh.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sh_unexpected: got %0d, expected no output", $signed(sh_dout));
      end else begin
        e = q_sh.pop_front();
        check("sh_dout", $signed(sh_dout), e);
        check("sh_sat", sh_sat, 0);
      end
    end
  end

  // OUT_W=8 monitor.
  always @(negedge clk) begin
    int e;
    bit s;
    if (ow_valid === 1'b1) begin
      if (q_ow.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ow_unexpected: got %0d, expected no output", $signed(ow_dout));
      end else begin
        e = q_ow.pop_front();
        s = q_ows.pop_front();
        check("ow_dout", $signed(ow_dout), e);
        check("ow_sat", ow_sat, s);
      end
    end
  end

  // Issue one beat to the main DUT; expected value is queued when it is accepted.
  task automatic send(input int a, input int b, input int c, input bit acc, input int exp);
    int  w = 0;
    bit  done = 0;
    in_a     = 12'(a);
    in_b     = 9'(b);
    in_c     = 21'(c);
    in_acc   = acc;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        q_m.push_back(exp);
        done = 1;
      end else begin
        rdy_low++;
        w++;
        if (w > 200) begin
          check("send_timeout", w, 0);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Issue one beat to both auxiliary DUTs.
  task automatic send2(input int a, input int b, input int c, input int e_sh,
                       input int e_ow, input bit s_ow);
    int w = 0;
    bit done = 0;
    x_a = 12'(a);
    x_b = 9'(b);
    x_c = 21'(c);
    x_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (sh_ready === 1'b1 && ow_ready === 1'b1) begin
        q_sh.push_back(e_sh);
        q_ow.push_back(e_ow);
        q_ows.push_back(s_ow);
        done = 1;
      end else begin
        w++;
        if (w > 200) begin
          check("send2_timeout", w, 0);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    x_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q_m.size() + q_sh.size() + q_ow.size()) != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("drain_left", q_m.size() + q_sh.size() + q_ow.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic int model(input int a, input int b, input int c);
    return a * b + c;
  endfunction

  // Auxiliary vectors: A, B, C, SHIFT=4 result, OUT_W=8 result and clip flag.
  int va[11]  = '{1, 1, 1, 1, 100, 100, 0, 0, 0, 0, 0};
  int vb[11]  = '{8, -24, 7, -8, 100, -100, 0, 0, 0, 0, 0};
  int vc[11]  = '{0, 0, 0, 0, 0, 0, -5, 127, 128, -128, -129};
  int vsh[11] = '{1, -1, 0, 0, 625, -625, 0, 8, 8, -8, -8};
`ifdef PP_MULADD_SAT_EN
  int vow[11] = '{8, -24, 7, -8, 127, -128, -5, 127, 127, -128, -128};
  bit vos[11] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1};
`else
  int vow[11] = '{8, -24, 7, -8, 16, -16, -5, 127, -128, -128, 127};
  bit vos[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; in_acc = 1'b0;
    out_ready = 1'b1; x_valid = 1'b0; x_a = '0; x_b = '0; x_c = '0; x_acc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_dout", $signed(out_dout), 0);
    check("reset_out_sat", out_sat, 0);
    check("reset_aux_valid", {sh_valid, ow_valid}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // First beat and its latency.
    send(4095, -256, 1000, 0, -1047320);
    @(negedge clk); check("lat_c1_valid", out_valid, 0);
    @(negedge clk); check("lat_c2_valid", out_valid, 0);
    @(negedge clk); check("lat_c3_valid", out_valid, 1);
    @(posedge clk);
    #1;
    drain();

    // Eight back-to-back beats.
    rdy_low = 0;
    max_run = 0;
    for (int i = 0; i < 8; i++)
      send(50 * i + 7, 13 * i - 60, 1000 * i - 3000, 0,
           model(50 * i + 7, 13 * i - 60, 1000 * i - 3000));
    drain();
    check("stream_in_ready_low", rdy_low, 0);
    check("stream_valid_run", max_run, 8);

    // Stall with a full pipe, then release.
    out_ready = 1'b0;
    send(11, 12, 13, 0, 145);
    send(-1 & 4095, 2, 0, 0, 8190);
    send(3, -3, -1, 0, -10);
    fork
      send(20, 20, 20, 0, 420);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_dout", $signed(out_dout), 145);
          check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random in_valid gaps with random back-pressure.
    done_rand = 0;
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          ra = $urandom_range(0, 4095);
          rb = $urandom_range(0, 511) - 256;
          rc = $urandom_range(0, 1048576) - 524288;
          send(ra, rb, rc, 0, model(ra, rb, rc));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        done_rand = 1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Accumulate, back-to-back and with bubbles.
    send(10, 3, 5, 0, 35);
    send(2, -4, 0, 1, 27);
    send(1, 1, 0, 1, 28);
    drain();
    send(10, 3, 5, 0, 35);
    @(posedge clk); #1;
    send(2, -4, 0, 1, 27);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(1, 1, 0, 1, 28);
    drain();

    // Rounding and output-width vectors.
    for (int i = 0; i < 11; i++)
      send2(va[i], vb[i], vc[i], vsh[i], vow[i], vos[i]);
    drain();

    // Reset in the middle of a stream.
    send(5, 5, 0, 0, 25);
    send(6, 6, 0, 0, 36);
    send(7, 7, 0, 0, 49);
    check("mid_valid_before", out_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_reset_valid", out_valid, 0);
    check("mid_reset_dout", $signed(out_dout), 0);
    check("mid_reset_sat", out_sat, 0);
    q_m.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_valid", out_valid, 0);
    @(posedge clk);
    #1;
    send(1, 1, 0, 1, 1);
    drain();
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
